shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Sequencer that drives a serial shift-register chain (single-bit `d`/`dout`, DEPTH flop stages) from a parallel word interface. It shifts a captured word through the chain MSB-first, flushes it, and reassembles the bits returning on the chain output into a parallel result. The block sits between a word-level producer/consumer and any serial shift datapath. It gives a cycle-exact loopback check of the chain's stage count.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `DEPTH`, 2, number of flop stages in the controlled chain (≥1)
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  producer has a word
- `in_ready`  output  1  controller can accept a word
- `in_data`  input  WIDTH  word to shift, MSB first
- `sr_en`  output  1  shift enable to the chain; the chain advances on edges where it is high
- `sr_d`  output  1  serial bit into the chain (`d`)
- `sr_dout`  input  1  serial bit out of the chain (`dout`)
- `out_valid`  output  1  reassembled word available
- `out_ready`  input  1  consumer takes the word
- `out_data`  output  WIDTH  reassembled word
- `busy`  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load `in_data` into tx register, clear cnt and rx, go to SHIFT.
- SHIFT:
  - `sr_en`=1.
  - `sr_d` = tx[WIDTH-1] while cnt<WIDTH, else 0 (flush).
  - tx shifts left by one each cycle.
  - When cnt≥DEPTH, rx <= {rx[WIDTH-2:0], sr_dout} at the end of that cycle.
  - cnt increments each cycle. After cnt = WIDTH+DEPTH-1, go to DONE.
- DONE:
  - `out_valid`=1, `out_data`=rx, held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is high only in IDLE; there is no bypass from DONE to SHIFT.
- `sr_en`=0 and `sr_d`=0 in IDLE and DONE.
- Width rules:
  - cnt is $clog2(WIDTH+DEPTH+1) bits wide.
  - rx and tx are exactly WIDTH bits; bits shifted out are discarded.
- A correct chain yields `out_data` == accepted `in_data`.
- A chain with k fewer stages than DEPTH yields (in_data << k) truncated to WIDTH bits, with zeros filled in from the flush.

## Timing
- Reset (synchronous): state IDLE, `in_ready`=1, `sr_en`=0, `sr_d`=0, `out_valid`=0, `out_data`=0, `busy`=0, cnt/tx/rx=0.
- Reset wins over every other input in the same cycle.
- Reset mid-SHIFT or mid-DONE aborts the operation: on the next cycle `sr_en`=0, no `out_valid`, and the word is dropped.
- Acceptance edge E0 → SHIFT occupies exactly WIDTH+DEPTH cycles with `sr_en`=1 → `out_valid` rises after edge E0+WIDTH+DEPTH.
- `out_ready` held low: DONE persists indefinitely, with `out_data` unchanged.
- DONE with `out_ready`=1 → IDLE on the next edge. The earliest next acceptance is the edge after that, so throughput is one word per WIDTH+DEPTH+2 cycles.
- `in_valid` while not in IDLE is ignored; `in_data` is not sampled.
- `sr_dout` is sampled only in SHIFT with cnt≥DEPTH and ignored otherwise.

## Structure
- Package `shift_seq_pkg`:
  - state enum (IDLE, SHIFT, DONE)
  - function returning the cnt width for given WIDTH/DEPTH
- No sub-module: FSM, counter, tx and rx registers live in one module.

## Test plan
Bench setup: WIDTH=8, DEPTH=2, behavioural enabled 2-flop chain model.
- Hold `reset`=1 for 3 cycles with `in_valid`=1 → `in_ready`=1, `sr_en`=0, `out_valid`=0, `out_data`=0, `busy`=0 throughout.
- Accept 0xA5 → `sr_d` sequence 1,0,1,0,0,1,0,1,0,0 with `sr_en` high exactly 10 cycles; `out_valid` after 10 edges; `out_data`=0xA5.
- 0x3C then 0xC3, each offered while `in_ready`=0 → each accepted only in IDLE; outputs 0x3C then 0xC3, with a 12-cycle accept-to-accept interval and `out_ready` tied high.
- Accept 0xFF with `out_ready` low for 5 cycles → `out_valid` and `out_data`=0xFF stable for all 5 cycles; IDLE one edge after `out_ready` rises.
- Assert `reset` at cnt=4 of SHIFT → IDLE next cycle, `sr_en`=0, no `out_valid`; then 0x81 completes as 0x81.
- Swap in a 1-stage chain model (stage collapsed) and accept 0xA5 → `out_data`=0x4A, flagging the missing stage.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and sizing helpers for the serial shift-chain sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // The counter must reach WIDTH+DEPTH-1, the last shift cycle.
  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Shifts a parallel word MSB-first through an external serial chain, flushes it,
// and reassembles the bits that come back out of the chain into a parallel word.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_en,
  output logic             sr_d,
  input  logic             sr_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] RX_FROM = CW'(DEPTH);
  localparam logic [CW-1:0] TX_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] rx;

  assign out_data = rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      in_ready  <= 1'b1;
      sr_en     <= 1'b0;
      sr_d      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tx       <= in_data;
            rx       <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            sr_en    <= 1'b1;
            sr_d     <= in_data[WIDTH-1];
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          tx  <= {tx[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          // The first DEPTH bits out of the chain are stale contents, not our word.
          if (cnt >= RX_FROM) rx <= {rx[WIDTH-2:0], sr_dout};
          if (cnt == LAST) begin
            state     <= DONE;
            sr_en     <= 1'b0;
            sr_d      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            // sr_d is registered, so it carries the bit for the next count value.
            sr_d <= (cnt < TX_LAST) ? tx[WIDTH-2] : 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          sr_en     <= 1'b0;
          sr_d      <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
